// File: rtl/seg7_scan_driver.sv
// Eight-digit common-anode seven-segment scanner: time-multiplexes eight 5-bit
// character codes, latching the input bus only at frame wrap so a scan never tears.
module seg7_scan_driver #(
  parameter int          REFRESH_DIV  = 100000,
  parameter int          BLANK_CYCLES = 0,
  parameter logic [7:0]  DP_MASK      = 8'b00010100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [39:0] display,
  input  logic        enable,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       digit_sel_q, digit_sel_d;
  logic [39:0]      shadow_q, shadow_d;
  logic             load_pending_q;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             tick;
  logic             in_blank;
  logic [5:0]       code_base;
  logic [4:0]       code;

  // Compare as int so BLANK_CYCLES = 0 does not produce a constant unsigned compare.
  assign tick      = (int'(div_cnt_q) == REFRESH_DIV - 1);
  assign in_blank  = (int'(div_cnt_q) < BLANK_CYCLES);
  assign code_base = 6'(digit_sel_q) * 6'd5;
  assign code      = shadow_q[code_base +: 5];

  always_comb begin
    div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
    digit_sel_d = tick ? digit_sel_q + 3'd1 : digit_sel_q;
    shadow_d    = shadow_q;
    // First cycle out of reset, and the tick that ends digit 7, are the only load points.
    if (load_pending_q || (tick && (digit_sel_q == 3'd7))) begin
      shadow_d = display;
    end
    an_d = (enable && !in_blank) ? ~(8'b1 << digit_sel_q) : 8'hFF;
    dp_d = ~DP_MASK[digit_sel_q];
    case (code)
      5'h00: seg_d = 7'h40;
      5'h01: seg_d = 7'h79;
      5'h02: seg_d = 7'h24;
      5'h03: seg_d = 7'h30;
      5'h04: seg_d = 7'h19;
      5'h05: seg_d = 7'h12;
      5'h06: seg_d = 7'h02;
      5'h07: seg_d = 7'h78;
      5'h08: seg_d = 7'h00;
      5'h09: seg_d = 7'h10;
      5'h0A: seg_d = 7'h08;
      5'h0B: seg_d = 7'h03;
      5'h0C: seg_d = 7'h46;
      5'h0D: seg_d = 7'h21;
      5'h0E: seg_d = 7'h06;
      5'h0F: seg_d = 7'h0E;
      5'h10: seg_d = 7'h3F;  // '-'
      5'h11: seg_d = 7'h09;  // 'H'
      5'h12: seg_d = 7'h47;  // 'L'
      5'h13: seg_d = 7'h0C;  // 'P'
      5'h14: seg_d = 7'h2F;  // 'r'
      5'h15: seg_d = 7'h23;  // 'o'
      5'h16: seg_d = 7'h2B;  // 'n'
      5'h17: seg_d = 7'h41;  // 'U'
      5'h18: seg_d = 7'h07;  // 't'
      5'h19: seg_d = 7'h11;  // 'y'
      default: seg_d = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q      <= '0;
      digit_sel_q    <= 3'd0;
      shadow_q       <= 40'hFF_FFFF_FFFF;
      load_pending_q <= 1'b1;
      an_q           <= 8'hFF;
      seg_q          <= 7'h7F;
      dp_q           <= 1'b1;
    end else begin
      div_cnt_q      <= div_cnt_d;
      digit_sel_q    <= digit_sel_d;
      shadow_q       <= shadow_d;
      load_pending_q <= 1'b0;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (no blanking / one blank cycle) share
// inputs; the driver queues each cycle's expected outputs and a monitor compares them.
module tb_seg7_scan_driver;

  localparam int         R    = 4;
  localparam logic [7:0] MASK = 8'b00010100;

  logic        clk;
  logic        reset;
  logic [39:0] display;
  logic        enable;
  logic [7:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;

  seg7_scan_driver #(.REFRESH_DIV(R), .BLANK_CYCLES(0), .DP_MASK(MASK)) dut (
    .clk(clk), .reset(reset), .display(display), .enable(enable),
    .an(an_a), .seg(seg_a), .dp(dp_a)
  );

  seg7_scan_driver #(.REFRESH_DIV(R), .BLANK_CYCLES(1), .DP_MASK(MASK)) dut_b (
    .clk(clk), .reset(reset), .display(display), .enable(enable),
    .an(an_b), .seg(seg_b), .dp(dp_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hand-computed active-low segment table {g,f,e,d,c,b,a}
  logic [6:0] seg_tbl [32];
  initial begin
    seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
                7'h3F, 7'h09, 7'h47, 7'h0C, 7'h2F, 7'h23, 7'h2B, 7'h41,
                7'h07, 7'h11, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  end

  // scoreboard: entry = {an_a, an_b, seg, dp}
  logic [23:0] exp_q [$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [23:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("an",     an_a,         e[23:16]);
      chk("an_blk", an_b,         e[15:8]);
      chk("seg",    {1'b0, seg_a}, {1'b0, e[7:1]});
      chk("seg_blk",{1'b0, seg_b}, {1'b0, e[7:1]});
      chk("dp",     {7'b0, dp_a},  {7'b0, e[0]});
    end
  end

  // model state: cycles since reset release, latched frame contents, first-load flag
  int          m_cyc;
  logic [39:0] m_shadow;
  logic        m_first;

  task automatic step(input logic rst, input logic en, input logic [39:0] disp);
    int          digit, pos;
    logic [4:0]  code;
    logic [7:0]  ea, eb, onehot_n;
    logic [6:0]  es;
    logic        ed;
    @(negedge clk);
    reset   = rst;
    enable  = en;
    display = disp;
    if (rst) begin
      ea = 8'hFF; eb = 8'hFF; es = 7'h7F; ed = 1'b1;
      m_cyc = 0; m_shadow = 40'hFF_FFFF_FFFF; m_first = 1'b1;
    end else begin
      digit    = (m_cyc / R) % 8;
      pos      = m_cyc % R;
      code     = m_shadow[5*digit +: 5];
      onehot_n = ~(8'b1 << digit);
      es = seg_tbl[code];
      ed = ~MASK[digit];
      ea = en ? onehot_n : 8'hFF;
      eb = (en && pos >= 1) ? onehot_n : 8'hFF;
      if (m_first || (digit == 7 && pos == R - 1)) m_shadow = disp;
      m_first = 1'b0;
      m_cyc++;
    end
    exp_q.push_back({ea, eb, es, ed});
  endtask

  task automatic run(input int n, input logic en, input logic [39:0] disp);
    for (int i = 0; i < n; i++) step(1'b0, en, disp);
  endtask

  logic [39:0] d;

  initial begin
    reset = 1'b1; enable = 1'b1;
    d = {5'h1F, 5'h1F, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06};
    display = d;
    m_cyc = 0; m_shadow = 40'hFF_FFFF_FFFF; m_first = 1'b1;

    // reset, then one full frame and digits 0..2 of the next
    repeat (3) step(1'b1, 1'b1, d);
    run(44, 1'b1, d);

    // digit 0 changes while digit 3 is lit; visible only after the wrap
    d[4:0] = 5'h09;
    run(61, 1'b1, d);

    // enable low for 10 cycles starting mid-digit-2
    run(10, 1'b0, d);
    run(43, 1'b1, d);

    // reset in the middle of a slot, then restart from digit 0
    step(1'b1, 1'b1, d);
    run(40, 1'b1, d);

    // decode sweep: every code on every digit
    for (int c = 0; c < 32; c++) begin
      d = {8{5'(c)}};
      run(32, 1'b1, d);
    end
    run(40, 1'b1, d);

    @(posedge clk);
    #3;
    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
